// File: rtl/rv64_decode_stage.sv
// rv64_decode_stage: registered RV64I decode stage with a valid/ready handshake on
// both sides. A single bundle register holds the decoded ALU controls and the
// register/control fields for the execute stage.
module rv64_decode_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            flush_in,
    input  logic            in_valid_in,
    output logic            in_ready_out,
    input  logic [XLEN-1:0] pc_in,
    input  logic [31:0]     instr_in,
    output logic            out_valid_out,
    input  logic            out_ready_in,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      alu_op_out,
    output logic            sub_sra_out,
    output logic [2:0]      src1_out,
    output logic [2:0]      src2_out,
    output logic [XLEN-1:0] imm_out,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic            rd_we_out,
    output logic            word_out,
    output logic            load_out,
    output logic            store_out,
    output logic            branch_out,
    output logic            jump_out,
    output logic [2:0]      funct3_out,
    output logic            illegal_out
);

    localparam logic [4:0] OP_ADD_SUB = 5'b00000;
    localparam logic [4:0] OP_XOR     = 5'b01001;
    localparam logic [4:0] OP_OR      = 5'b10010;
    localparam logic [4:0] OP_AND     = 5'b11011;
    localparam logic [4:0] OP_SLL     = 5'b00100;
    localparam logic [4:0] OP_SRL_SRA = 5'b01101;
    localparam logic [4:0] OP_SLT     = 5'b10110;
    localparam logic [4:0] OP_SLTU    = 5'b11111;

    localparam logic [2:0] SRC1_REG  = 3'b000;
    localparam logic [2:0] SRC1_PC   = 3'b101;
    localparam logic [2:0] SRC1_ZERO = 3'b010;
    localparam logic [2:0] SRC2_REG  = 3'b000;
    localparam logic [2:0] SRC2_IMM  = 3'b101;
    localparam logic [2:0] SRC2_CONST = 3'b010;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      alu_op;
        logic            sub_sra;
        logic [2:0]      src1;
        logic [2:0]      src2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rd_we;
        logic            word;
        logic            load;
        logic            store;
        logic            branch;
        logic            jump;
        logic [2:0]      funct3;
        logic            illegal;
    } bundle_t;

    bundle_t dec;
    bundle_t held;
    logic    out_valid_q;
    logic    xfer;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [5:0]      top6;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt6, shamt5;

    // Register-register and register-immediate ops share the same funct3 mapping
    function automatic logic [4:0] op_from_f3(input logic [2:0] f);
        logic [4:0] op;
        case (f)
            3'b000:  op = OP_ADD_SUB;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL_SRA;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

    assign opcode = instr_in[6:0];
    assign f3     = instr_in[14:12];
    assign f7     = instr_in[31:25];
    assign top6   = instr_in[31:26];

    assign imm_i  = {{(XLEN-12){instr_in[31]}}, instr_in[31:20]};
    assign imm_s  = {{(XLEN-12){instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
    assign imm_b  = {{(XLEN-13){instr_in[31]}}, instr_in[31], instr_in[7],
                     instr_in[30:25], instr_in[11:8], 1'b0};
    assign imm_u  = {{(XLEN-32){instr_in[31]}}, instr_in[31:12], 12'b0};
    assign imm_j  = {{(XLEN-21){instr_in[31]}}, instr_in[31], instr_in[19:12],
                     instr_in[20], instr_in[30:21], 1'b0};
    assign shamt6 = {{(XLEN-6){1'b0}}, instr_in[25:20]};
    assign shamt5 = {{(XLEN-5){1'b0}}, instr_in[24:20]};

    // Decode the presented instruction into a complete output bundle
    always_comb begin
        dec         = '0;
        dec.pc      = pc_in;
        dec.rs1     = instr_in[19:15];
        dec.rs2     = instr_in[24:20];
        dec.rd      = instr_in[11:7];
        dec.funct3  = f3;
        dec.alu_op  = OP_ADD_SUB;
        dec.src1    = SRC1_REG;
        dec.src2    = SRC2_REG;
        dec.rd_we   = 1'b1;
        case (opcode)
            OPC_LUI: begin
                dec.src1 = SRC1_ZERO;
                dec.src2 = SRC2_IMM;
                dec.imm  = imm_u;
            end
            OPC_AUIPC: begin
                dec.src1 = SRC1_PC;
                dec.src2 = SRC2_IMM;
                dec.imm  = imm_u;
            end
            OPC_JAL: begin
                dec.src1 = SRC1_PC;
                dec.src2 = SRC2_CONST;
                dec.imm  = imm_j;
                dec.jump = 1'b1;
            end
            OPC_JALR: begin
                dec.src1    = SRC1_PC;
                dec.src2    = SRC2_CONST;
                dec.imm     = imm_i;
                dec.jump    = 1'b1;
                dec.illegal = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.rd_we  = 1'b0;
                dec.branch = 1'b1;
                dec.imm    = imm_b;
                case (f3)
                    3'b000, 3'b001: dec.sub_sra = 1'b1;
                    3'b100, 3'b101: dec.alu_op  = OP_SLT;
                    3'b110, 3'b111: dec.alu_op  = OP_SLTU;
                    default:        dec.illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.src2    = SRC2_IMM;
                dec.imm     = imm_i;
                dec.load    = 1'b1;
                dec.illegal = (f3 == 3'b111);
            end
            OPC_STORE: begin
                dec.src2    = SRC2_IMM;
                dec.imm     = imm_s;
                dec.store   = 1'b1;
                dec.rd_we   = 1'b0;
                dec.illegal = f3[2];
            end
            OPC_OP_IMM: begin
                dec.src2   = SRC2_IMM;
                dec.imm    = imm_i;
                dec.alu_op = op_from_f3(f3);
                if (f3 == 3'b001) begin
                    dec.imm     = shamt6;
                    dec.illegal = (top6 != 6'b000000);
                end else if (f3 == 3'b101) begin
                    dec.imm     = shamt6;
                    dec.sub_sra = instr_in[30];
                    dec.illegal = (top6 != 6'b000000) && (top6 != 6'b010000);
                end
            end
            OPC_OP: begin
                dec.alu_op = op_from_f3(f3);
                if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
                    dec.sub_sra = 1'b1;
                end else if (f7 != F7_BASE) begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OP_IMM32: begin
                dec.word = 1'b1;
                dec.src2 = SRC2_IMM;
                case (f3)
                    3'b000: dec.imm = imm_i;
                    3'b001: begin
                        dec.alu_op  = OP_SLL;
                        dec.imm     = shamt5;
                        dec.illegal = (f7 != F7_BASE);
                    end
                    3'b101: begin
                        dec.alu_op  = OP_SRL_SRA;
                        dec.imm     = shamt5;
                        dec.sub_sra = instr_in[30];
                        dec.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_OP_32: begin
                dec.word = 1'b1;
                case (f3)
                    3'b000: begin
                        dec.sub_sra = (f7 == F7_ALT);
                        dec.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                    3'b001: begin
                        dec.alu_op  = OP_SLL;
                        dec.illegal = (f7 != F7_BASE);
                    end
                    3'b101: begin
                        dec.alu_op  = OP_SRL_SRA;
                        dec.sub_sra = (f7 == F7_ALT);
                        dec.illegal = (f7 != F7_BASE) && (f7 != F7_ALT);
                    end
                    default: dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.rd_we  = 1'b0;
            dec.load   = 1'b0;
            dec.store  = 1'b0;
            dec.branch = 1'b0;
            dec.jump   = 1'b0;
        end
        if (dec.rd == 5'd0) begin
            dec.rd_we = 1'b0;
        end
    end

    assign in_ready_out = !out_valid_q || out_ready_in;
    assign xfer         = in_valid_in && in_ready_out;

    // Bundle register: flush beats transfer, transfer beats drain; fields hold on drain
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_valid_q <= 1'b0;
            held        <= '0;
            held.pc     <= RESET_PC;
        end else if (flush_in) begin
            out_valid_q <= 1'b0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            held        <= dec;
        end else if (out_ready_in) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_out = out_valid_q;
    assign pc_out        = held.pc;
    assign alu_op_out    = held.alu_op;
    assign sub_sra_out   = held.sub_sra;
    assign src1_out      = held.src1;
    assign src2_out      = held.src2;
    assign imm_out       = held.imm;
    assign rs1_out       = held.rs1;
    assign rs2_out       = held.rs2;
    assign rd_out        = held.rd;
    assign rd_we_out     = held.rd_we;
    assign word_out      = held.word;
    assign load_out      = held.load;
    assign store_out     = held.store;
    assign branch_out    = held.branch;
    assign jump_out      = held.jump;
    assign funct3_out    = held.funct3;
    assign illegal_out   = held.illegal;

endmodule

// File: tb/tb_rv64_decode_stage.sv
// tb_rv64_decode_stage: directed bench for the RV64I decode stage; expected bundles
// are hand-decoded per instruction word, queued on input handshake and compared on
// output handshake.
module tb_rv64_decode_stage;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] pc_in;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] pc_out;
    logic [4:0]  alu_op;
    logic        sub_sra;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        word;
    logic        load;
    logic        store;
    logic        branch;
    logic        jump;
    logic [2:0]  funct3;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [63:0] pc;
        logic        full;
        logic        has_imm;
        logic        illegal;
        logic        rd_we;
        logic        load;
        logic        store;
        logic        branch;
        logic        jump;
        logic [4:0]  op;
        logic        sub;
        logic [2:0]  src1;
        logic [2:0]  src2;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        word;
        logic [2:0]  f3;
    } exp_t;

    exp_t sb[$];

    logic [31:0] stream_vec [13] = '{
        32'h402081B3, 32'h43F0D093, 32'h00208463, 32'h123452B7, 32'h800000B7,
        32'hFFDFF0EF, 32'h41F0D09B, 32'h0210909B, 32'h0020B423, 32'hFFF0B283,
        32'h00000013, 32'h007332B3, 32'h00001517
    };

    rv64_decode_stage #(.XLEN(64), .RESET_PC(RESET_PC)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .flush_in      (flush),
        .in_valid_in   (in_valid),
        .in_ready_out  (in_ready),
        .pc_in         (pc_in),
        .instr_in      (instr),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .pc_out        (pc_out),
        .alu_op_out    (alu_op),
        .sub_sra_out   (sub_sra),
        .src1_out      (src1),
        .src2_out      (src2),
        .imm_out       (imm),
        .rs1_out       (rs1),
        .rs2_out       (rs2),
        .rd_out        (rd),
        .rd_we_out     (rd_we),
        .word_out      (word),
        .load_out      (load),
        .store_out     (store),
        .branch_out    (branch),
        .jump_out      (jump),
        .funct3_out    (funct3),
        .illegal_out   (illegal)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Hard stop so the run always ends even if the handshake locks up
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] pc, input logic [4:0] op, input logic sub,
                                input logic [2:0] s1, input logic [2:0] s2, input logic hi,
                                input logic [63:0] im, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rdx, input logic we, input logic [2:0] f3,
                                input logic [4:0] flags);
        exp_t e;
        e = '0;
        e.pc = pc; e.full = 1'b1; e.has_imm = hi; e.rd_we = we;
        {e.word, e.load, e.store, e.branch, e.jump} = flags;
        e.op = op; e.sub = sub; e.src1 = s1; e.src2 = s2; e.imm = im;
        e.rs1 = r1; e.rs2 = r2; e.rd = rdx; e.f3 = f3;
        return e;
    endfunction

    // Hand-decoded expectations for every instruction word this bench drives
    function automatic exp_t golden(input logic [63:0] pc, input logic [31:0] ins);
        exp_t e;
        case (ins)
            32'h00500093: e = mk(pc, 5'b00000, 0, 3'b000, 3'b101, 1, 64'd5, 0, 5, 1, 1, 3'b000, 5'b00000);
            32'h402081B3: e = mk(pc, 5'b00000, 1, 3'b000, 3'b000, 0, 64'd0, 1, 2, 3, 1, 3'b000, 5'b00000);
            32'h43F0D093: e = mk(pc, 5'b01101, 1, 3'b000, 3'b101, 1, 64'd63, 1, 31, 1, 1, 3'b101, 5'b00000);
            32'h00208463: e = mk(pc, 5'b00000, 1, 3'b000, 3'b000, 1, 64'd8, 1, 2, 8, 0, 3'b000, 5'b00010);
            32'h123452B7: e = mk(pc, 5'b00000, 0, 3'b010, 3'b101, 1, 64'h12345000, 8, 3, 5, 1, 3'b101, 5'b00000);
            32'h800000B7: e = mk(pc, 5'b00000, 0, 3'b010, 3'b101, 1, 64'hFFFF_FFFF_8000_0000, 0, 0, 1, 1, 3'b000, 5'b00000);
            32'hFFDFF0EF: e = mk(pc, 5'b00000, 0, 3'b101, 3'b010, 1, 64'hFFFF_FFFF_FFFF_FFFC, 31, 29, 1, 1, 3'b111, 5'b00001);
            32'h41F0D09B: e = mk(pc, 5'b01101, 1, 3'b000, 3'b101, 1, 64'd31, 1, 31, 1, 1, 3'b101, 5'b10000);
            32'h0020B423: e = mk(pc, 5'b00000, 0, 3'b000, 3'b101, 1, 64'd8, 1, 2, 8, 0, 3'b011, 5'b00100);
            32'hFFF0B283: e = mk(pc, 5'b00000, 0, 3'b000, 3'b101, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 31, 5, 1, 3'b011, 5'b01000);
            32'h00000013: e = mk(pc, 5'b00000, 0, 3'b000, 3'b101, 1, 64'd0, 0, 0, 0, 0, 3'b000, 5'b00000);
            32'h007332B3: e = mk(pc, 5'b11111, 0, 3'b000, 3'b000, 0, 64'd0, 6, 7, 5, 1, 3'b011, 5'b00000);
            32'h00001517: e = mk(pc, 5'b00000, 0, 3'b101, 3'b101, 1, 64'h1000, 0, 0, 10, 1, 3'b001, 5'b00000);
            default: begin
                e = '0;
                e.pc = pc;
                e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

    // Scoreboard: pop and compare on output handshake, push on input handshake
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checkOutput("output_expected", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("ctrl", {pc_out, illegal, rd_we, load, store, branch, jump},
                                {e.pc, e.illegal, e.rd_we, e.load, e.store, e.branch, e.jump});
                    if (e.full) begin
                        checkOutput("alu", {alu_op, sub_sra, src1, src2, rs1, rs2, rd, word, funct3},
                                    {e.op, e.sub, e.src1, e.src2, e.rs1, e.rs2, e.rd, e.word, e.f3});
                    end
                    if (e.has_imm) begin
                        checkOutput("imm", imm, e.imm);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(golden(pc_in, instr));
            end
        end
    end

    task automatic applyStimulus(input logic [63:0] pc, input logic [31:0] ins);
        int cnt;
        in_valid = 1'b1;
        pc_in    = pc;
        instr    = ins;
        cnt      = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!in_ready && cnt < 100);
        checkOutput("accept", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Directed sequence
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pc_in     = '0;
        instr     = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_pc", pc_out, RESET_PC);
        checkOutput("reset_imm", imm, 0);
        checkOutput("reset_fields", {alu_op, sub_sra, src1, src2, rs1, rs2, rd, rd_we, word,
                                     load, store, branch, jump, funct3, illegal}, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] addi latency");
        out_ready = 1'b1;
        applyStimulus(64'h1000, 32'h00500093);
        checkOutput("latency_valid", out_valid, 1);
        checkOutput("latency_pc", pc_out, 64'h1000);

        $display("[TB] back-to-back decode stream");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(64'h2000 + 64'(i * 4), stream_vec[i]);
        end
        @(posedge clk);
        #1;
        checkOutput("drain_valid", out_valid, 0);
        checkOutput("drain_pc_hold", pc_out, 64'h2000 + 64'd48);

        $display("[TB] stalled stream");
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(64'h3000, 32'h00500093);
                applyStimulus(64'h3004, 32'h402081B3);
                applyStimulus(64'h3008, 32'h43F0D093);
                applyStimulus(64'h300C, 32'h00208463);
            end
            begin
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", in_ready, 0);
                    checkOutput("stall_valid", out_valid, 1);
                    checkOutput("stall_pc", pc_out, 64'h3000);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        checkOutput("stream_drained", sb.size(), 0);

        $display("[TB] flush of held bundle");
        out_ready = 1'b0;
        applyStimulus(64'h4000, 32'h00500093);
        checkOutput("flush_pre_valid", out_valid, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_held", out_valid, 0);

        $display("[TB] flush with concurrent transfer");
        in_valid = 1'b1;
        pc_in    = 64'h4004;
        instr    = 32'h00500093;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_xfer", out_valid, 0);

        $display("[TB] illegal word");
        out_ready = 1'b1;
        applyStimulus(64'h5000, 32'hFFFFFFFF);
        checkOutput("illegal_flag", illegal, 1);
        checkOutput("illegal_rd_we", rd_we, 0);
        applyStimulus(64'h5004, 32'h00001517);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(64'h6000, 32'h007332B3);
        checkOutput("pre_reset_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_valid", out_valid, 0);
        checkOutput("midreset_pc", pc_out, RESET_PC);
        checkOutput("midreset_rd", {rd, rd_we}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(64'h7000, 32'h00500093);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_queue_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
